add_serial_issue: RTL

- Issue stage that sits directly in front of the 8-bit bit-serial adder.
- Buffers incoming operand pairs in a small FIFO, launches one addition at a time on the adder's start interface, and waits a fixed latency. It then captures the adder's parallel sum and presents it downstream on a valid/ready handshake.
- Lets upstream logic stream operand pairs without tracking the adder's multi-cycle busy window.

---
 rtl/add_serial_issue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/add_serial_issue.sv
// Issue stage in front of the 8-bit bit-serial adder: buffers operand pairs,
// launches one addition at a time, waits a fixed latency and hands the sum downstream.
module add_serial_issue #(
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [7:0]                 in_b,
    output logic                       add_en,
    output logic [7:0]                 add_a,
    output logic [7:0]                 add_b,
    input  logic [7:0]                 add_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [7:0]                 res_sum,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     occ
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int CW = $clog2(ADD_LAT);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem_a [DEPTH];
    logic [7:0]      mem_b [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push, launch, load_cnt, capture, release_res;

    assign in_ready = (occ != OW'(DEPTH));
    assign push     = in_valid & in_ready;

    always_comb begin
        state_nx    = state;
        launch      = 1'b0;
        load_cnt    = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            S_IDLE: begin
                if (occ != '0) begin
                    launch   = 1'b1;
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                load_cnt = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (launch) rd_ptr <= rd_ptr + PW'(1);
            case ({push, launch})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_en    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            busy      <= 1'b0;
        end else begin
            add_en <= launch;
            busy   <= (state_nx != S_IDLE);
            if (launch) begin
                add_a <= mem_a[rd_ptr];
                add_b <= mem_b[rd_ptr];
            end
            // Loaded with ADD_LAT-2 so res_valid rises ADD_LAT cycles after add_en.
            if (load_cnt)
                cnt <= CW'(ADD_LAT - 2);
            else if (state == S_WAIT && cnt != '0)
                cnt <= cnt - CW'(1);
            if (capture) begin
                res_sum   <= add_out;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule
